// File: rtl/axil_pkg.sv
// AXI4-Lite response codes and FSM state types shared by axil_slave_mem and its bench.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/axil_slave_mem_array.sv
// Byte-strobed word array: one synchronous write port, one combinational read port.
module axil_slave_mem_array #(
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 64,
  localparam int STRB_W   = DATA_W / 8,
  localparam int WORDS    = MEM_BYTES / STRB_W,
  localparam int IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  // NOTE: non-blocking (<=) for every flop so all registers update together at the edge.
  // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int w = 0; w < WORDS; w++) mem_q[w] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave memory. Read channel is built only with AXIL_SLAVE_MEM_RD_EN defined;
// otherwise AR/R ports exist but ARREADY, RVALID, RDATA and RRESP are tied to 0.
module axil_slave_mem
  import axil_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int WORDS  = MEM_BYTES / STRB_W;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a < ADDR_W'(MEM_BYTES)) && (a[OFF_W-1:0] == '0);
  endfunction

  wr_state_e         wr_state_q, wr_state_d;
  logic              aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_raddr;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state_q <= W_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bresp_q    <= bresp_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_state_d = wr_state_q;
    aw_full_d  = aw_full_q;
    w_full_d   = w_full_q;
    aw_addr_d  = aw_addr_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    if (AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (WVALID && wready_q) begin
      w_full_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    case (wr_state_q)
      W_IDLE: begin
        // A holder can only be loaded while empty, so a commit never races a capture.
        if (aw_full_q && w_full_q) begin
          mem_we     = addr_ok(aw_addr_q);
          bresp_d    = addr_ok(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
          aw_full_d  = 1'b0;
          w_full_d   = 1'b0;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bresp_d    = RESP_OKAY;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    awready_d = !aw_full_d;
    wready_d  = !w_full_d;
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = (wr_state_q == W_RESP);
  assign BRESP   = bresp_q;

  axil_slave_mem_array #(
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES)
  ) u_array (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .we_i    (mem_we),
    .waddr_i (aw_addr_q[OFF_W +: IDX_W]),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

`ifdef AXIL_SLAVE_MEM_RD_EN
  rd_state_e         rd_state_q, rd_state_d;
  logic              arready_q, arready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Array read is sampled before the edge, so a same-edge write yields the old word.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          rd_state_d = R_DATA;
          rdata_d    = addr_ok(ARADDR) ? mem_rdata : '0;
          rresp_d    = addr_ok(ARADDR) ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          rd_state_d = R_IDLE;
          rdata_d    = '0;
          rresp_d    = RESP_OKAY;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    arready_d = (rd_state_d == R_IDLE);
  end

  assign mem_raddr = ARADDR[OFF_W +: IDX_W];
  assign ARREADY   = arready_q;
  assign RVALID    = (rd_state_q == R_DATA);
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
`else
  logic unused_rd;
  assign unused_rd = ^{ARADDR, ARVALID, RREADY, mem_rdata};
  assign mem_raddr = '0;
  assign ARREADY   = 1'b0;
  assign RVALID    = 1'b0;
  assign RDATA     = '0;
  assign RRESP     = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axil_slave_mem.sv
// Directed bench for axil_slave_mem (default parameters); read checks adapt to AXIL_SLAVE_MEM_RD_EN.
module tb_axil_slave_mem;
  import axil_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_BYTES = 64;
`ifdef AXIL_SLAVE_MEM_RD_EN
  localparam logic RD_EN = 1'b1;
`else
  localparam logic RD_EN = 1'b0;
`endif

  logic                ACLK = 1'b0;
  logic                ARESET;
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  int checks = 0;
  int errors = 0;

  axil_slave_mem #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic aw_acc, w_acc;
    AWADDR  = addr;
    WDATA   = data;
    WSTRB   = strb;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    for (int i = 0; i < 20 && (AWVALID || WVALID); i++) begin
      aw_acc = AWREADY;
      w_acc  = WREADY;
      tick();
      if (aw_acc) AWVALID = 1'b0;
      if (w_acc) WVALID = 1'b0;
    end
    check("aw_w_accepted", {AWVALID, WVALID}, 2'b00);
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  task automatic finish_b(input logic [1:0] exp_resp);
    for (int i = 0; i < 20 && !BVALID; i++) tick();
    check("bvalid", BVALID, 1'b1);
    check("bresp", BRESP, exp_resp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_clear", BVALID, 1'b0);
    check("bresp_clear", BRESP, RESP_OKAY);
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
`ifdef AXIL_SLAVE_MEM_RD_EN
    ARADDR  = addr;
    ARVALID = 1'b1;
    for (int i = 0; i < 20 && !ARREADY; i++) tick();
    check("arready", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    check("rvalid", RVALID, 1'b1);
    check("rdata", RDATA, exp_data);
    check("rresp", RRESP, exp_resp);
    tick();
    check("rdata_hold", RDATA, exp_data);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rvalid_clear", RVALID, 1'b0);
    check("rdata_clear", RDATA, 32'h0);
    check("rresp_clear", RRESP, RESP_OKAY);
    check("arready_again", ARREADY, 1'b1);
`else
    check("arready_tied", ARREADY, 1'b0);
    check("rvalid_tied", RVALID, 1'b0);
    check("rdata_tied", RDATA, 32'h0);
    if (exp_resp == RESP_OKAY) check("mem_word", dut.u_array.mem_q[addr[5:2]], exp_data);
`endif
  endtask

  initial begin
    ARESET  = 1'b1;
    AWADDR  = '0;
    AWVALID = 1'b0;
    WDATA   = '0;
    WSTRB   = '0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    ARADDR  = '0;
    ARVALID = 1'b0;
    RREADY  = 1'b0;

    // Reset state and first edge after release
    tick();
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_bresp", BRESP, 2'b00);
    check("rst_rdata", RDATA, 32'h0);
    tick();
    tick();
    ARESET = 1'b0;
    tick();
    check("rel_awready", AWREADY, 1'b1);
    check("rel_wready", WREADY, 1'b1);
    check("rel_arready", ARREADY, RD_EN);

    // Full-word write and read back
    send_aw_w(32'h04, 32'h11223344, 4'hF);
    finish_b(RESP_OKAY);
    read_word(32'h04, 32'h11223344, RESP_OKAY);

    // W leads AW by three cycles, partial strobe
    WDATA  = 32'hAABBCCDD;
    WSTRB  = 4'h5;
    WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    check("wready_after_capture", WREADY, 1'b0);
    check("awready_w_only", AWREADY, 1'b1);
    tick();
    tick();
    check("no_bvalid_w_only", BVALID, 1'b0);
    AWADDR  = 32'h08;
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("bvalid_not_yet", BVALID, 1'b0);
    tick();
    check("bvalid_after_aw", BVALID, 1'b1);
    finish_b(RESP_OKAY);
    read_word(32'h08, 32'h00BB00DD, RESP_OKAY);

    // Out-of-range and misaligned writes, invalid read
    send_aw_w(32'h40, 32'hFFFFFFFF, 4'hF);
    finish_b(RESP_SLVERR);
    send_aw_w(32'h02, 32'hFFFFFFFF, 4'hF);
    finish_b(RESP_SLVERR);
    read_word(32'h00, 32'h0, RESP_OKAY);
    read_word(32'h40, 32'h0, RESP_SLVERR);
    read_word(32'h04, 32'h11223344, RESP_OKAY);

    // B back-pressure: response held, next write captured but not committed
    send_aw_w(32'h44, 32'h0BADF00D, 4'hF);
    for (int i = 0; i < 20 && !BVALID; i++) tick();
    send_aw_w(32'h10, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      check("bvalid_hold", BVALID, 1'b1);
      check("bresp_hold", BRESP, RESP_SLVERR);
      check("awready_held", AWREADY, 1'b0);
      tick();
    end
    read_word(32'h10, 32'h0, RESP_OKAY);
    finish_b(RESP_SLVERR);
    finish_b(RESP_OKAY);
    read_word(32'h10, 32'hCAFEF00D, RESP_OKAY);

    // Reset while BVALID is high
    send_aw_w(32'h14, 32'h12345678, 4'hF);
    for (int i = 0; i < 20 && !BVALID; i++) tick();
    check("bvalid_before_reset", BVALID, 1'b1);
    ARESET = 1'b1;
    tick();
    check("reset_bvalid", BVALID, 1'b0);
    check("reset_awready", AWREADY, 1'b0);
    ARESET = 1'b0;
    tick();
    check("rel2_awready", AWREADY, 1'b1);
    check("rel2_wready", WREADY, 1'b1);
    check("rel2_arready", ARREADY, RD_EN);
    read_word(32'h04, 32'h0, RESP_OKAY);
    read_word(32'h14, 32'h0, RESP_OKAY);
    read_word(32'h10, 32'h0, RESP_OKAY);

    // Same-edge commit and read of one word returns the old data
    send_aw_w(32'h0C, 32'h9, 4'hF);
    finish_b(RESP_OKAY);
    AWADDR  = 32'h0C;
    WDATA   = 32'h5;
    WSTRB   = 4'hF;
    AWVALID = 1'b1;
    WVALID  = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("collide_aw_taken", AWREADY, 1'b0);
`ifdef AXIL_SLAVE_MEM_RD_EN
    ARADDR  = 32'h0C;
    ARVALID = 1'b1;
`endif
    tick();
`ifdef AXIL_SLAVE_MEM_RD_EN
    ARVALID = 1'b0;
    check("collide_rvalid", RVALID, 1'b1);
    check("collide_rdata", RDATA, 32'h9);
    check("collide_rresp", RRESP, RESP_OKAY);
    RREADY = 1'b1;
`endif
    check("collide_bvalid", BVALID, 1'b1);
    check("collide_bresp", BRESP, RESP_OKAY);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    RREADY = 1'b0;
    check("collide_bvalid_clear", BVALID, 1'b0);
    read_word(32'h0C, 32'h5, RESP_OKAY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_slave_mem.md
AXIL_SLAVE_MEM -- requirements
Module: axil_slave_mem

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL take parameter DATA_W, default 32, data width in bits; legal values are 32 and 64.
REQ-003 SHALL take parameter MEM_BYTES, default 64, memory size in bytes; must be a power of two and at least DATA_W/8.
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock.
REQ-005 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have AW ports: AWADDR input ADDR_W, AWVALID input 1, AWREADY output 1.
REQ-007 SHALL have W ports: WDATA input DATA_W, WSTRB input DATA_W/8, WVALID input 1, WREADY output 1.
REQ-008 SHALL have B ports: BRESP output 2, BVALID output 1, BREADY input 1.
REQ-009 SHALL have AR ports: ARADDR input ADDR_W, ARVALID input 1, ARREADY output 1.
REQ-010 SHALL have R ports: RDATA output DATA_W, RRESP output 2, RVALID output 1, RREADY input 1.

Function
REQ-011 SHALL accept AW and W independently, each into a one-entry holding register; a transfer occurs when VALID&&READY at a rising ACLK edge.
REQ-012 SHALL drive AWREADY=1 while the AW holder is empty, and WREADY=1 while the W holder is empty; both are registered outputs.
REQ-013 SHALL run the write FSM as W_IDLE -> W_RESP: when both holders are full in W_IDLE, commit the write on that edge, then assert BVALID on the next cycle and clear both holders.
REQ-014 SHALL treat an address as valid when addr < MEM_BYTES and addr[log2(DATA_W/8)-1:0]==0; otherwise the address is invalid.
REQ-015 SHALL, for a valid write, update byte lane i only if WSTRB[i]=1 and return BRESP=2'b00 (OKAY); for an invalid write, leave memory unchanged and return BRESP=2'b10 (SLVERR).
REQ-016 SHALL hold BVALID and BRESP stable until BREADY=1, then return to W_IDLE; new AW/W transfers MAY be captured while in W_RESP, but SHALL NOT commit before returning to W_IDLE.
REQ-017 SHALL run the read FSM as R_IDLE -> R_DATA: ARREADY=1 only in R_IDLE; on AR handshake, RDATA/RRESP/RVALID become valid on the next cycle (1-cycle latency).
REQ-018 SHALL return memory contents with RRESP=OKAY for a valid read, and RDATA=0 with RRESP=SLVERR for an invalid read.
REQ-019 SHALL hold RVALID, RDATA and RRESP stable until RREADY=1, then return to R_IDLE; the next ARREADY comes one cycle later.
REQ-020 SHALL, when a write commit and an AR handshake target the same word on the same edge, return the pre-write data.
REQ-021 SHALL keep BRESP=0 while BVALID=0, and RDATA=0 and RRESP=0 while RVALID=0.

Reset
REQ-022 SHALL, while ARESET=1 at an edge, set AWREADY, WREADY, ARREADY, BVALID and RVALID to 0, clear BRESP, RRESP, RDATA and both holders, and enter W_IDLE and R_IDLE.
REQ-023 SHALL clear all memory bytes to 0 on reset.
REQ-024 SHALL assert AWREADY, WREADY and ARREADY on the first edge after ARESET deasserts.
REQ-025 SHALL abort any in-flight transaction on reset mid-operation, with no memory update.

Configuration
REQ-026 SHALL, with AXIL_SLAVE_MEM_RD_EN defined, implement the AR and R channels per REQ-017 to REQ-020.
REQ-027 SHALL, without AXIL_SLAVE_MEM_RD_EN, keep the AR/R ports but tie ARREADY, RVALID, RDATA and RRESP to 0, with no read logic.

Structure
REQ-028 SHALL take from package axil_pkg the constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 and the write/read state typedefs.
REQ-029 SHALL instantiate the sub-module axil_slave_mem_array: a byte-strobed register array with one write port and one read port, parametrised by DATA_W and MEM_BYTES.

Verification
REQ-030 SHALL cover: write 0x11223344, strobe 0xF, to 0x04, then read 0x04 -> BRESP=OKAY, RDATA=0x11223344 with RRESP=OKAY one cycle after the AR handshake.
REQ-031 SHALL cover: W arrives 3 cycles before AW, with data 0xAABBCCDD and strobe 0x5 to 0x08 over prior 0 -> WREADY=0 after capture, BVALID 1 cycle after AW, read 0x08 = 0x00BB00DD.
REQ-032 SHALL cover: write to 0x40 (MEM_BYTES=64) and to 0x02 -> BRESP=SLVERR for both, memory unchanged; read 0x40 -> RRESP=SLVERR, RDATA=0.
REQ-033 SHALL cover: BREADY held at 0 for 5 cycles -> BVALID and BRESP stable; the following AW/W are captured but not committed until B completes.
REQ-034 SHALL cover: ARESET pulsed with BVALID=1 -> BVALID=0 next cycle, memory reads back 0, READY signals high one cycle after release.
REQ-035 SHALL cover: same-cycle write 0x5 and read of 0x0C holding 0x9 -> RDATA=0x9; a subsequent read returns 0x5.
